// File: rtl/rect_plotter_pkg.sv
// Shared types and constants for the rectangle rasteriser: screen limits,
// FSM states, the queued command record and the basic palette.
package rect_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int COORD_W    = 8;
    localparam int COLOUR_W   = 3;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW,
        FINISH
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [COORD_W-1:0]  w;
        logic [COORD_W-1:0]  h;
        logic [COLOUR_W-1:0] colour;
    } rect_cmd_t;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;
    localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] RED   = 3'b100;

endpackage

// File: rtl/rect_plotter_if.sv
// Rectangle command channel: valid/ready handshake plus the command fields.
interface rect_plotter_if;

    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [rect_pkg::COORD_W-1:0]     cmd_x;
    logic [rect_pkg::COORD_W-1:0]     cmd_y;
    logic [rect_pkg::COORD_W-1:0]     cmd_w;
    logic [rect_pkg::COORD_W-1:0]     cmd_h;
    logic [rect_pkg::COLOUR_W-1:0]    cmd_colour;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
        output cmd_ready
    );

endinterface

// File: rtl/rect_plotter_cmd_fifo.sv
// Small synchronous command queue; full/empty come straight from the
// registered occupancy count so the producer sees no same-cycle pop path.
module cmd_fifo
    import rect_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic      clock,
    input  logic      resetn,
    input  logic      push,
    input  logic      pop,
    input  rect_cmd_t din,
    output rect_cmd_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    rect_cmd_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle rasteriser: queues draw commands and streams one clipped pixel
// write per clock in row-major order towards the VGA adapter.
//
// state  | meaning
// IDLE   | waiting for a queued command; pops the head when one exists
// LOAD   | clip bounds computed; first pixel position registered
// DRAW   | plot asserted, walking columns then rows
// FINISH | one-cycle done pulse
module rect_plotter
    import rect_pkg::*;
#(
    parameter int SCREEN_W = rect_pkg::SCREEN_W,
    parameter int SCREEN_H = rect_pkg::SCREEN_H
) (
    input  logic                clock,
    input  logic                resetn,
    rect_plotter_if.slave       cmd_if,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(SCREEN_H);

    rect_cmd_t           cmd_in;
    rect_cmd_t           head;
    rect_cmd_t           work;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    state_t              state;
    state_t              state_nxt;
    logic [COORD_W-1:0]  cur_x;
    logic [COORD_W-1:0]  cur_y;
    logic [COLOUR_W-1:0] colour_q;
    logic [COORD_W:0]    x_end;
    logic [COORD_W:0]    y_end;
    logic [COORD_W:0]    x_sum;
    logic [COORD_W:0]    y_sum;
    logic [COORD_W:0]    x_end_c;
    logic [COORD_W:0]    y_end_c;
    logic [COORD_W:0]    x_inc;
    logic [COORD_W:0]    y_inc;
    logic                empty_cmd;
    logic                last_col;
    logic                last_row;

    assign cmd_in = '{x: cmd_if.cmd_x, y: cmd_if.cmd_y, w: cmd_if.cmd_w,
                      h: cmd_if.cmd_h, colour: cmd_if.cmd_colour};
    assign cmd_if.cmd_ready = !fifo_full;

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (cmd_if.cmd_valid),
        .pop    (pop),
        .din    (cmd_in),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Bounds are one bit wider than the coordinates so x+w never wraps.
    always_comb begin
        x_sum     = {1'b0, work.x} + {1'b0, work.w};
        y_sum     = {1'b0, work.y} + {1'b0, work.h};
        x_end_c   = (x_sum > X_LIM) ? X_LIM : x_sum;
        y_end_c   = (y_sum > Y_LIM) ? Y_LIM : y_sum;
        empty_cmd = (work.w == '0) || (work.h == '0) ||
                    ({1'b0, work.x} >= X_LIM) || ({1'b0, work.y} >= Y_LIM);
        x_inc     = {1'b0, cur_x} + (COORD_W+1)'(1);
        y_inc     = {1'b0, cur_y} + (COORD_W+1)'(1);
        last_col  = (x_inc == x_end);
        last_row  = (y_inc == y_end);
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD:    state_nxt = empty_cmd ? FINISH : DRAW;
            DRAW:    if (last_col && last_row) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            work     <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            colour_q <= '0;
            x_end    <= '0;
            y_end    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (pop) work <= head;
                LOAD: begin
                    x_end <= x_end_c;
                    y_end <= y_end_c;
                    if (!empty_cmd) begin
                        cur_x    <= work.x;
                        cur_y    <= work.y;
                        colour_q <= work.colour;
                    end
                end
                DRAW: begin
                    if (!last_col) begin
                        cur_x <= x_inc[COORD_W-1:0];
                    end else if (!last_row) begin
                        cur_x <= work.x;
                        cur_y <= y_inc[COORD_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign x      = cur_x;
    assign y      = cur_y;
    assign colour = colour_q;
    assign plot   = (state == DRAW);
    assign done   = (state == FINISH);
    assign busy   = !fifo_empty || (state != IDLE);

endmodule
